// File: rtl/register_pkg.sv
// Shared definitions for the register serializer: state encoding and counter sizing.
package register_pkg;

    typedef logic state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Bit counter wide enough to hold WIDTH+1 without wrapping inside a word.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Synchronous up-counter with clear, enable and a registered terminal-count flag.
module serializer_bit_counter #(
    parameter int             CW       = 3,
    parameter logic [CW-1:0]  TERMINAL = '1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          tc_reg;

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = count_reg + 1'b1;
        end
    end

    // tc is registered alongside the count so it is true in the cycle the count equals TERMINAL.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= (count_next == TERMINAL);
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;

endmodule

// File: rtl/register_serializer.sv
// Parallel-in/serial-out serializer, LSB first, with ready/valid/done strobes.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module register_serializer
    import register_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] I,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [NBITS-1:0]   shreg_reg;
    logic [NBITS-1:0]   shreg_next;
    logic [NBITS-1:0]   load_word;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               last_bit;
    logic               cnt_clear;
    logic               cnt_en;
    logic               ready_reg;
    logic               ready_next;
    logic               sout_reg;
    logic               sout_next;
    logic               valid_reg;
    logic               valid_next;

    // Parity rides as the top bit of the shift register so it simply shifts out last.
`ifdef SERIALIZER_PARITY_EN
    assign load_word = {^I, I};
`else
    assign load_word = I;
`endif

    assign accept   = (state_reg == ST_IDLE) && load;
    assign last_bit = (state_reg == ST_SHIFT) && (cnt == LAST_CNT);

    assign cnt_clear = clear || (state_reg == ST_IDLE) || last_bit;
    assign cnt_en    = (state_reg == ST_SHIFT);

    serializer_bit_counter #(
        .CW       (CW),
        .TERMINAL (LAST_CNT)
    ) u_bit_counter (
        .clk   (clk),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (cnt),
        .tc    (done)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        if (state_reg == ST_IDLE) begin
            if (load) begin
                state_next = ST_SHIFT;
                shreg_next = load_word;
            end
        end else begin
            shreg_next = shreg_reg >> 1;
            if (last_bit) begin
                state_next = ST_IDLE;
            end
        end
    end

    // Outputs are derived from next-state values and registered so they line up with the state.
    always_comb begin
        ready_next = (state_next == ST_IDLE);
        valid_next = (state_next == ST_SHIFT);
        sout_next  = valid_next && shreg_next[0];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            ready_reg <= 1'b1;
            sout_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            ready_reg <= ready_next;
            sout_reg  <= sout_next;
            valid_reg <= valid_next;
        end
    end

    assign ready      = ready_reg;
    assign sout       = sout_reg;
    assign sout_valid = valid_reg;

endmodule

// File: tb/tb_register_serializer.sv
// Directed self-checking bench for register_serializer (WIDTH=4).
module tb_register_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       clear;
    logic       load;
    logic [3:0] I;
    logic       ready;
    logic       sout;
    logic       sout_valid;
    logic       done;

    int checks   = 0;
    int failures = 0;

    register_serializer #(.WIDTH(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .load       (load),
        .I          (I),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, ready, 1'b1);
        chk({tag, "_valid"}, sout_valid, 1'b0);
        chk({tag, "_sout"}, sout, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        $display("t=%0t %s idle ready=%b valid=%b sout=%b done=%b", $time, tag, ready, sout_valid, sout, done);
    endtask

    // Bit k of a word: data bits LSB first, then the even-parity bit when enabled.
    task automatic check_shift(input string tag, input logic [3:0] word, input int k);
        logic exp_bit;
        exp_bit = (k < 4) ? word[k] : ^word;
        chk($sformatf("%s_b%0d_sout", tag, k), sout, exp_bit);
        chk($sformatf("%s_b%0d_valid", tag, k), sout_valid, 1'b1);
        chk($sformatf("%s_b%0d_ready", tag, k), ready, 1'b0);
        chk($sformatf("%s_b%0d_done", tag, k), done, (k == NB - 1));
        $display("t=%0t %s bit%0d sout=%b valid=%b ready=%b done=%b", $time, tag, k, sout, sout_valid, ready, done);
    endtask

    // Called in the first SHIFT cycle; returns in the following idle cycle.
    task automatic check_word(input string tag, input logic [3:0] word);
        for (int k = 0; k < NB; k++) begin
            check_shift(tag, word, k);
            tick();
        end
        check_idle({tag, "_gap"});
    endtask

    initial begin
        clear = 1'b1;
        load  = 1'b1;
        I     = 4'b1111;

        // 1: reset for two edges, with a competing load that must be dropped
        tick();
        tick();
        check_idle("reset");
        clear = 1'b0;
        load  = 1'b0;
        tick();
        check_idle("post_reset");

        // 2: single word 0101 -> 1,0,1,0
        I    = 4'b0101;
        load = 1'b1;
        tick();
        load = 1'b0;
        I    = 4'b0000;
        check_word("w0101", 4'b0101);

        // 3: load held high, I changes mid-word; back-to-back words with one idle gap
        I    = 4'b1001;
        load = 1'b1;
        tick();
        I = 4'b0110;
        check_word("w1001", 4'b1001);
        tick();
        load = 1'b0;
        check_word("w0110", 4'b0110);

        // 4: load pulse during SHIFT is ignored
        I    = 4'b0011;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_shift("w0011", 4'b0011, 0);
        tick();
        check_shift("w0011", 4'b0011, 1);
        I    = 4'b1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 2; k < NB; k++) begin
            check_shift("w0011", 4'b0011, k);
            tick();
        end
        check_idle("w0011_gap");
        tick();
        check_idle("w1111_never");

        // 5: clear on the second bit aborts the word without done
        I    = 4'b1011;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_shift("w1011", 4'b1011, 0);
        tick();
        check_shift("w1011", 4'b1011, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_idle("abort");
        tick();
        check_idle("abort_after");

        // 6: 0111 -> 1,1,1,0 (+ parity 1 when enabled)
        I    = 4'b0111;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_word("w0111", 4'b0111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
